// File: rtl/port_share_sched.sv
// Round-robin share of one in-order datapath among NUM_REQ requesters.
// A tag FIFO remembers who issued each transaction; a timeout drops stuck heads.
module port_share_sched #(
    parameter int NUM_REQ = 4,
    parameter int DW      = 8,
    parameter int MAX_OUT = 4,
    parameter int TIMEOUT = 5
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*DW-1:0]          req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           in_en,
    output logic [DW-1:0]                  portin,
    input  logic                           out_en,
    input  logic [DW-1:0]                  portout,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [DW-1:0]                  rsp_data,
    output logic                           timeout_err,
    output logic                           spurious_err,
    output logic [$clog2(MAX_OUT+1)-1:0]   occ
);
    localparam int OW  = $clog2(MAX_OUT + 1);
    localparam int GW  = $clog2(NUM_REQ);
    localparam int AW  = $clog2(MAX_OUT);
    localparam int TSW = $clog2(TIMEOUT + 2) + 1;

    logic [GW-1:0]      ptr_q, ptr_d;
    logic [OW-1:0]      occ_q, occ_d;
    logic [AW-1:0]      wr_q, rd_q;
    logic [TSW-1:0]     now_q;
    logic [GW-1:0]      tag_g_q [MAX_OUT];
    logic [TSW-1:0]     tag_s_q [MAX_OUT];

    logic               in_en_q, in_en_d;
    logic [DW-1:0]      portin_q, portin_d;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]      rsp_data_q, rsp_data_d;
    logic               tmo_q, tmo_d;
    logic               spur_q, spur_d;

    logic               gnt_hit;
    logic [GW-1:0]      gnt_idx, cand;
    logic               empty, pop_rsp, pop_tmo, pop;
    logic [GW-1:0]      head_g;
    logic [TSW-1:0]     age;

    // Grant only looks at registered occupancy, so a same-cycle pop never frees a slot early.
    always_comb begin
        gnt_hit = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        if (!rst && (occ_q < OW'(MAX_OUT))) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                cand = GW'((int'(ptr_q) + k) % NUM_REQ);
                if (!gnt_hit && req_valid[cand]) begin
                    gnt_hit = 1'b1;
                    gnt_idx = cand;
                end
            end
        end
    end

    assign req_ready = gnt_hit ? (NUM_REQ'(1) << gnt_idx) : '0;

    assign empty   = (occ_q == '0);
    assign head_g  = tag_g_q[rd_q];
    assign age     = now_q - tag_s_q[rd_q];
    assign pop_rsp = out_en && !empty;
    assign pop_tmo = !out_en && !empty && (age == TSW'(TIMEOUT + 1));
    assign pop     = pop_rsp || pop_tmo;

    always_comb begin
        ptr_d       = ptr_q;
        if (gnt_hit) begin
            ptr_d = (gnt_idx == GW'(NUM_REQ - 1)) ? '0 : gnt_idx + GW'(1);
        end
        occ_d       = occ_q + OW'(gnt_hit) - OW'(pop);
        in_en_d     = gnt_hit;
        portin_d    = gnt_hit ? req_data[gnt_idx*DW +: DW] : '0;
        rsp_valid_d = pop_rsp ? (NUM_REQ'(1) << head_g) : '0;
        rsp_data_d  = pop_rsp ? portout : '0;
        tmo_d       = pop_tmo;
        spur_d      = out_en && empty && !gnt_hit;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q       <= '0;
            occ_q       <= '0;
            wr_q        <= '0;
            rd_q        <= '0;
            now_q       <= '0;
            in_en_q     <= 1'b0;
            portin_q    <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            tmo_q       <= 1'b0;
            spur_q      <= 1'b0;
            for (int i = 0; i < MAX_OUT; i++) begin
                tag_g_q[i] <= '0;
                tag_s_q[i] <= '0;
            end
        end else begin
            ptr_q       <= ptr_d;
            occ_q       <= occ_d;
            now_q       <= now_q + TSW'(1);
            in_en_q     <= in_en_d;
            portin_q    <= portin_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            tmo_q       <= tmo_d;
            spur_q      <= spur_d;
            // Stamp with the issue cycle's time so the head is age 0 while in_en is high.
            if (gnt_hit) begin
                tag_g_q[wr_q] <= gnt_idx;
                tag_s_q[wr_q] <= now_q + TSW'(1);
                wr_q          <= wr_q + AW'(1);
            end
            if (pop) begin
                rd_q <= rd_q + AW'(1);
            end
        end
    end

    assign in_en        = in_en_q;
    assign portin       = portin_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_data     = rsp_data_q;
    assign timeout_err  = tmo_q;
    assign spurious_err = spur_q;
    assign occ          = occ_q;

endmodule
